// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch queue slice.
//   FETCH_DATA_W  default width of PC and instruction fields
//   NOP_INST      instruction word that is driven when the queue presents nothing
//   fetch_entry_t one buffered fetch result {pc, inst}
//   clog2         ceiling log2, used to size pointers and the occupancy count
package fetch_pkg;

  localparam int FETCH_DATA_W = 32;
  localparam logic [FETCH_DATA_W-1:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry register array for the fetch queue.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears all entries)
//   we_i      write enable
//   waddr_i   write index
//   wdata_i   write data
//   raddr_i   read index (asynchronous read)
//   rdata_o   entry at raddr_i
module fetch_queue_mem #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: buffers fetch-stage results (PC+4, instruction) ahead of decode.
// The full flag (~in_ready) is the fetch-stage freeze; flush is the branch-taken
// strobe that also redirects the fetch PC.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_pc/in_inst      fetched instruction presented by fetch
//   in_ready                    queue can accept (registered state only)
//   flush                       discard all buffered and incoming entries
//   out_valid/out_pc/out_inst   head entry (zero / NOP when not valid)
//   out_ready                   decode accepts the head entry
//   count                       current occupancy
// Build option: define FETCHQ_BYPASS_EN to let an incoming instruction reach
// out_* in the same cycle when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [DATA_W-1:0]       in_inst,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_pc,
  output logic [DATA_W-1:0]       out_inst,
  input  logic                    out_ready,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                empty, byp, push, pop, wr_en;
  logic [2*DATA_W-1:0] rd_entry;

  assign empty    = (cnt_q == '0);
  // Full check uses only registered occupancy: a pop this cycle does not free
  // the slot until the next one, keeping out_ready off the freeze path.
  assign in_ready = (cnt_q != FULL);

`ifdef FETCHQ_BYPASS_EN
  assign byp = ~rst & empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign push  = in_valid & in_ready & ~flush;
  assign pop   = ~empty & out_ready & ~flush;
  // A bypassed entry taken by decode the same cycle never touches storage.
  assign wr_en = push & ~(byp & out_ready);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) wp_d = wp_q + AW'(1);
      if (pop)   rp_d = rp_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (2*DATA_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (wp_q),
    .wdata_i ({in_pc, in_inst}),
    .raddr_i (rp_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    out_valid = ~empty | byp;
    out_pc    = '0;
    out_inst  = DATA_W'(NOP_INST);
    if (byp)         {out_pc, out_inst} = {in_pc, in_inst};
    else if (~empty) {out_pc, out_inst} = rd_entry;
  end

  assign count = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = clog2(DEPTH) + 1;

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of entries decode should see, plus the
  // number of entries actually held in storage.
  fetch_entry_t exp_q[$];
  int           mcnt;
  logic [31:0]  cur_pc, cur_inst;
  bit           have;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle and retires
  // the head entry whenever decode takes it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("count", 64'(count), 64'(mcnt));
      check("in_ready", 64'(in_ready), 64'(mcnt < DEPTH));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        check("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
        if (out_ready && !flush && !rst) void'(exp_q.pop_front());
      end else begin
        check("out_pc_nop", 64'(out_pc), 64'h0);
        check("out_inst_nop", 64'(out_inst), 64'h0);
      end
    end
  end

  // One fetch cycle; pv/pr/pf are percent probabilities of in_valid,
  // out_ready and flush. The fetch side re-presents a refused instruction.
  task automatic cycle(input int pv, input int pr, input int pf);
    bit v, r, f, acc, bypc, spop;
    @(negedge clk);
    if (!have) begin cur_inst = $urandom; have = 1'b1; end
    v = ($urandom_range(99) < pv);
    r = ($urandom_range(99) < pr);
    f = ($urandom_range(99) < pf);
    in_valid = v; in_pc = cur_pc; in_inst = cur_inst; out_ready = r; flush = f;
    acc  = v && !f && (mcnt < DEPTH);
    spop = (mcnt > 0) && r && !f;
    bypc = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if (acc && mcnt == 0) begin
      exp_q.push_back('{pc: cur_pc, inst: cur_inst});
      bypc = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    if (f) begin
      exp_q.delete();
      mcnt   = 0;
      cur_pc = $urandom & 32'h0000fffc;
      have   = 1'b0;
    end else begin
      if (acc && !bypc) exp_q.push_back('{pc: cur_pc, inst: cur_inst});
      if (acc && !(bypc && r)) mcnt++;
      if (spop) mcnt--;
      if (acc) begin cur_pc += 32'd4; have = 1'b0; end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    mcnt = 0; cur_pc = 32'd4; have = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 64'(count), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)   cycle(100, 0, 0);    // fill, then held while full
    for (int i = 0; i < 4; i++)   cycle(100, 100, 0);  // drain from full
    for (int i = 0; i < 10; i++)  cycle(100, 100, 0);  // streaming, pointers wrap
    for (int i = 0; i < 300; i++) cycle(70, 60, 5);
    for (int i = 0; i < 100; i++) cycle(80, 50, 25);

    // Asynchronous reset between edges with the queue full.
    for (int i = 0; i < 3; i++)   cycle(100, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'h0);
    check("arst_in_ready", 64'(in_ready), 64'h1);
    check("arst_out_valid", 64'(out_valid), 64'h0);
    check("arst_out_pc", 64'(out_pc), 64'h0);
    check("arst_out_inst", 64'(out_inst), 64'h0);
    exp_q.delete();
    mcnt = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 200; i++) cycle(70, 60, 5);
    for (int i = 0; i < 200; i++) cycle(90, 20, 3);
    for (int i = 0; i < 20; i++)  cycle(0, 100, 0);

    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
